sfx_scheduler: RTL and testbench

- Arbitrates game sound-effect requests (paddle hit, wall hit, score) onto the single shared codec sample stream.
- Sequences one square-wave tone at a time, with a per-source pitch, a fixed duration and an inter-tone gap.
- Mixes the tone into the mic pass-through samples and drives the Audio_Controller read/write handshake.
- Sits between game logic and Audio_Controller.

---
 rtl/sfx_pkg.sv | 19 +
 rtl/sfx_tone_gen.sv | 35 +++
 rtl/sfx_scheduler.sv | 133 +++++++++++++
 tb/tb_sfx_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
// rtl/sfx_pkg.sv - shared types, saturation limits and pitch helper for the sfx scheduler
package sfx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } sfx_state_e;

  localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN = 32'h8000_0000;
  localparam int          PHASE_W = 16;

  // Higher source index means a lower pitch: half-period scales with index+1.
  function automatic logic [PHASE_W-1:0] half_period(input int idx, input int base);
    return PHASE_W'(base * (idx + 1));
  endfunction

endpackage

// File: rtl/sfx_tone_gen.sv
// rtl/sfx_tone_gen.sv - square-wave polarity generator advanced once per sample tick
module sfx_tone_gen
  import sfx_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               load,
  input  logic [PHASE_W-1:0] half_period,
  input  logic               tick,
  output logic               polarity
);

  logic [PHASE_W-1:0] phase_cnt;
  logic [PHASE_W-1:0] period_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      phase_cnt <= '0;
      period_q  <= '0;
      polarity  <= 1'b0;
    end else if (load) begin
      phase_cnt <= half_period;
      period_q  <= half_period;
      polarity  <= 1'b1;
    end else if (tick) begin
      if (phase_cnt <= PHASE_W'(1)) begin
        phase_cnt <= period_q;
        polarity  <= ~polarity;
      end else begin
        phase_cnt <= phase_cnt - PHASE_W'(1);
      end
    end
  end

endmodule

// File: rtl/sfx_scheduler.sv
// rtl/sfx_scheduler.sv - priority sound-effect sequencer mixing tones into the codec stream
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int          NUM_SRC          = 3,
  parameter logic [31:0] AMPLITUDE        = 32'd10000000,
  parameter int          DURATION         = 24000,
  parameter int          GAP_SAMPLES      = 2400,
  parameter int          BASE_HALF_PERIOD = 24,
  localparam int         ID_W             = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic [NUM_SRC-1:0] sfx_req,
  input  logic               audio_in_available,
  input  logic [31:0]        left_channel_audio_in,
  input  logic [31:0]        right_channel_audio_in,
  input  logic               audio_out_allowed,
  output logic               read_audio_in,
  output logic               write_audio_out,
  output logic [31:0]        left_channel_audio_out,
  output logic [31:0]        right_channel_audio_out,
  output logic               busy,
  output logic [ID_W-1:0]    active_id
);

  localparam logic [31:0] DUR_LOAD = 32'(DURATION);
  localparam logic [31:0] GAP_LOAD = 32'(GAP_SAMPLES);

  sfx_state_e         state;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] pending_n;
  logic [NUM_SRC-1:0] sel_mask;
  logic [NUM_SRC-1:0] act_mask;
  logic [NUM_SRC-1:0] req_mask;
  logic [ID_W-1:0]    sel_id;
  logic [31:0]        dur_cnt;
  logic [31:0]        gap_cnt;
  logic               tick;
  logic               pend_any;
  logic               preempt;
  logic               load;
  logic               same_req;
  logic               polarity;

  assign tick            = audio_in_available & audio_out_allowed;
  assign read_audio_in   = tick;
  assign write_audio_out = tick;
  assign busy            = (state != IDLE);

  always_comb begin
    sel_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i]) sel_id = ID_W'(i);
    end
  end

  assign pend_any = |pending;
  assign preempt  = (state == PLAY) && pend_any && (sel_id < active_id);
  assign load     = ((state == IDLE) && pend_any) || preempt;
  assign same_req = (state == PLAY) && sfx_req[active_id];

  // Re-triggering the source already playing extends it instead of queueing a repeat.
  always_comb begin
    sel_mask         = '0;
    sel_mask[sel_id] = 1'b1;
    act_mask            = '0;
    act_mask[active_id] = 1'b1;
    req_mask  = sfx_req & ~(same_req ? act_mask : '0);
    pending_n = (load ? (pending & ~sel_mask) : pending) | req_mask;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state     <= IDLE;
      pending   <= '0;
      active_id <= '0;
      dur_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      pending <= pending_n;
      if (load) begin
        active_id <= sel_id;
        dur_cnt   <= DUR_LOAD;
        state     <= PLAY;
      end else begin
        case (state)
          PLAY: begin
            if (same_req) begin
              dur_cnt <= DUR_LOAD;
            end else if (tick) begin
              if (dur_cnt <= 32'd1) begin
                gap_cnt <= GAP_LOAD;
                state   <= (GAP_SAMPLES == 0) ? IDLE : GAP;
              end else begin
                dur_cnt <= dur_cnt - 32'd1;
              end
            end
          end
          GAP: begin
            if (tick) begin
              if (gap_cnt <= 32'd1) state <= IDLE;
              else gap_cnt <= gap_cnt - 32'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  sfx_tone_gen u_tone (
    .clk         (CLOCK_50),
    .resetn      (resetn),
    .load        (load),
    .half_period (half_period(int'(sel_id), BASE_HALF_PERIOD)),
    .tick        (tick && (state == PLAY) && !load),
    .polarity    (polarity)
  );

  function automatic logic [31:0] mix(input logic [31:0] s, input logic pos);
    logic [32:0] sum;
    sum = pos ? ({s[31], s} + {1'b0, AMPLITUDE}) : ({s[31], s} - {1'b0, AMPLITUDE});
    if (sum[32] != sum[31]) return sum[32] ? SAT_MIN : SAT_MAX;
    return sum[31:0];
  endfunction

  assign left_channel_audio_out  = (state == PLAY) ? mix(left_channel_audio_in, polarity)
                                                   : left_channel_audio_in;
  assign right_channel_audio_out = (state == PLAY) ? mix(right_channel_audio_in, polarity)
                                                   : right_channel_audio_in;

endmodule

// File: tb/tb_sfx_scheduler.sv
// tb/tb_sfx_scheduler.sv - scoreboard bench for sfx_scheduler against a tick-level reference model
module tb_sfx_scheduler;

  localparam int DUR  = 8;
  localparam int GAPS = 2;
  localparam int BASE = 2;

  logic        CLOCK_50 = 1'b0;
  logic        resetn;
  logic [2:0]  sfx_req;
  logic        audio_in_available;
  logic        audio_out_allowed;
  logic [31:0] left_channel_audio_in;
  logic [31:0] right_channel_audio_in;
  logic        read_audio_in;
  logic        write_audio_out;
  logic [31:0] left_channel_audio_out;
  logic [31:0] right_channel_audio_out;
  logic        busy;
  logic [1:0]  active_id;

  sfx_scheduler #(
    .NUM_SRC          (3),
    .AMPLITUDE        (32'd10000000),
    .DURATION         (DUR),
    .GAP_SAMPLES      (GAPS),
    .BASE_HALF_PERIOD (BASE)
  ) dut (
    .CLOCK_50                (CLOCK_50),
    .resetn                  (resetn),
    .sfx_req                 (sfx_req),
    .audio_in_available      (audio_in_available),
    .left_channel_audio_in   (left_channel_audio_in),
    .right_channel_audio_in  (right_channel_audio_in),
    .audio_out_allowed       (audio_out_allowed),
    .read_audio_in           (read_audio_in),
    .write_audio_out         (write_audio_out),
    .left_channel_audio_out  (left_channel_audio_out),
    .right_channel_audio_out (right_channel_audio_out),
    .busy                    (busy),
    .active_id               (active_id)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    logic        busy;
    logic [1:0]  id;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: tone progress kept as elapsed/remaining tick counts.
  int         m_st = 0;  // 0 silent, 1 tone, 2 gap
  int         m_act = 0;
  int         m_elapsed = 0;
  int         m_remain = 0;
  int         m_gapleft = 0;
  logic [2:0] m_pend = 3'b000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int lowest(input logic [2:0] p);
    for (int i = 0; i < 3; i++) if (p[i]) return i;
    return 3;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] s, input bit pos);
    longint v;
    v = longint'($signed(s)) + (pos ? 64'sd10000000 : -64'sd10000000);
    if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (v < -64'sd2147483648) return 32'h8000_0000;
    return v[31:0];
  endfunction

  task automatic start_tone(input int id);
    m_act      = id;
    m_pend[id] = 1'b0;
    m_st       = 1;
    m_elapsed  = 0;
    m_remain   = DUR;
  endtask

  task automatic model_reset();
    m_st = 0; m_act = 0; m_pend = 3'b000; m_elapsed = 0; m_remain = 0; m_gapleft = 0;
  endtask

  // One slot: request cycle, two settle cycles, then a single sample tick.
  task automatic slot(input logic [2:0] req, input logic [31:0] sl, input logic [31:0] sr);
    exp_t e;
    bit   pos;
    if (m_st == 0 && m_pend != 3'b000) begin
      start_tone(lowest(m_pend));
      m_pend |= req;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (req[i]) begin
          if (m_st == 1 && i == m_act) m_remain = DUR;
          else m_pend[i] = 1'b1;
        end
      end
    end
    if (m_st == 0 && m_pend != 3'b000) start_tone(lowest(m_pend));
    else if (m_st == 1 && m_pend != 3'b000 && lowest(m_pend) < m_act) start_tone(lowest(m_pend));

    e.busy = (m_st != 0);
    e.id   = 2'(m_act);
    if (m_st == 1) begin
      pos = ((m_elapsed / (BASE * (m_act + 1))) % 2) == 0;
      e.l = sat_add(sl, pos);
      e.r = sat_add(sr, pos);
      m_elapsed++;
      m_remain--;
      if (m_remain == 0) begin
        m_gapleft = GAPS;
        m_st = (GAPS == 0) ? 0 : 2;
      end
    end else begin
      e.l = sl;
      e.r = sr;
      if (m_st == 2) begin
        m_gapleft--;
        if (m_gapleft == 0) m_st = 0;
      end
    end
    q.push_back(e);

    sfx_req = req;
    @(posedge CLOCK_50); #1 sfx_req = 3'b000;
    @(posedge CLOCK_50); #1;
    @(posedge CLOCK_50); #1;
    left_channel_audio_in  = sl;
    right_channel_audio_in = sr;
    audio_in_available     = 1'b1;
    audio_out_allowed      = 1'b1;
    @(posedge CLOCK_50); #1;
    audio_in_available     = 1'b0;
    audio_out_allowed      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) slot(3'b000, 32'h0, 32'h0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLOCK_50);
      if (write_audio_out) begin
        if (q.size() == 0) begin
          check("unexpected_tick", 32'(write_audio_out), 32'd0);
        end else begin
          e = q.pop_front();
          check("left_out", left_channel_audio_out, e.l);
          check("right_out", right_channel_audio_out, e.r);
          check("busy", 32'(busy), 32'(e.busy));
          check("active_id", 32'(active_id), 32'(e.id));
          check("read_audio_in", 32'(read_audio_in), 32'd1);
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] a;
    logic [31:0] b;
    resetn = 1'b0;
    sfx_req = 3'b000;
    audio_in_available = 1'b0;
    audio_out_allowed = 1'b0;
    left_channel_audio_in = 32'h0;
    right_channel_audio_in = 32'h0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_active_id", 32'(active_id), 32'd0);
    check("reset_write", 32'(write_audio_out), 32'd0);
    resetn = 1'b1;
    @(posedge CLOCK_50); #1;

    slot(3'b001, 32'h0, 32'h0);
    idle(12);

    slot(3'b110, 32'h0, 32'h0);
    idle(24);

    slot(3'b100, 32'h0, 32'h0);
    idle(2);
    slot(3'b001, 32'h0, 32'h0);
    idle(24);

    slot(3'b001, 32'h0, 32'h0);
    idle(5);
    slot(3'b001, 32'h0, 32'h0);
    idle(14);

    slot(3'b001, 32'h7FFF_FF00, 32'h8000_0010);
    slot(3'b000, 32'h7FFF_FF00, 32'h8000_0010);
    slot(3'b000, 32'h8000_0010, 32'h7FFF_FF00);
    slot(3'b000, 32'h8000_0010, 32'h7FFF_FF00);
    idle(8);

    slot(3'b001, 32'h0, 32'h0);
    idle(2);
    slot(3'b100, 32'h0, 32'h0);
    resetn = 1'b0;
    @(posedge CLOCK_50); #1;
    resetn = 1'b1;
    model_reset();
    left_channel_audio_in  = 32'h1234_5678;
    right_channel_audio_in = 32'hFEDC_BA98;
    @(negedge CLOCK_50);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_left", left_channel_audio_out, 32'h1234_5678);
    check("midreset_right", right_channel_audio_out, 32'hFEDC_BA98);
    @(posedge CLOCK_50); #1;
    idle(14);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0: a = 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
        1: a = 32'h8000_0000 + 32'($urandom_range(0, 255));
        default: a = $urandom;
      endcase
      b = $urandom;
      slot(($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000, a, b);
    end
    idle(24);

    repeat (8) @(posedge CLOCK_50);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
